// File: rtl/mod461_frame_acc.sv
// Frame accumulator: sums residue words modulo MOD per frame and
// presents sum, word count and an out-of-range flag once per frame.
module mod461_frame_acc #(
  parameter int MOD = 461,
  parameter int W   = 9,
  parameter int CW  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [CW-1:0] out_count,
  output logic          out_err
);

  typedef enum logic {ACC, HOLD} state_e;

  localparam logic [W-1:0] MOD_W = MOD[W-1:0];
  localparam logic [W:0]   MOD_X = MOD[W:0];

  state_e        state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic          accept;
  logic          over;
  logic [W-1:0]  d_red;
  logic [W:0]    sum;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    in_ready  = (state_q == ACC);
    out_valid = (state_q == HOLD);
    accept    = in_valid && in_ready;
    over      = (in_data >= MOD_W);
    d_red     = over ? (in_data - MOD_W) : in_data;
    sum       = {1'b0, acc_q} + {1'b0, d_red};

    unique case (state_q)
      ACC: begin
        if (accept) begin
          // s - MOD < MOD < 2^W, so the low W bits carry the result
          acc_d = (sum >= MOD_X) ? (sum[W-1:0] - MOD_W)
                                 : sum[W-1:0];
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
          err_d = err_q | over;
          if (in_last) state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACC;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign out_data  = acc_q;
  assign out_count = cnt_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_mod461_frame_acc.sv
// Bench for mod461_frame_acc: frame table plus stall, reset and
// saturation sequences, checked through an expected-result queue.
module tb_mod461_frame_acc;

  localparam int W  = 9;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_count;
  logic          out_err;

  always #5 clk = ~clk;

  mod461_frame_acc dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_count(out_count),
    .out_err  (out_err)
  );

  typedef struct {
    int              n;
    logic [3:0][8:0] w;
    bit              gap;
    int              e_data;
    int              e_cnt;
    int              e_err;
  } vec_t;

  typedef struct {
    int data;
    int cnt;
    int err;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[9];
  int   vecs = 0;
  int   miss = 0;

  task automatic chk(input string nm, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input int d, input bit last);
    int t;
    t = 0;
    while (!in_ready && t < 20) begin
      step();
      t++;
    end
    if (!in_ready) chk("in_ready_wait", 0, 1);
    in_valid = 1'b1;
    in_data  = W'(d);
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic push(input int d, input int c, input int e);
    exp_t x;
    x.data = d;
    x.cnt  = c;
    x.err  = e;
    sb.push_back(x);
  endtask

  task automatic collect(input string nm);
    exp_t x;
    int   t;
    t = 0;
    while (!out_valid && t < 20) begin
      step();
      t++;
    end
    chk({nm, "_valid"}, int'(out_valid), 1);
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 0, 1);
    end else begin
      x = sb.pop_front();
      chk({nm, "_data"}, int'(out_data), x.data);
      chk({nm, "_count"}, int'(out_count), x.cnt);
      chk({nm, "_err"}, int'(out_err), x.err);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({nm, "_ready_after"}, int'(in_ready), 1);
    chk({nm, "_valid_drop"}, int'(out_valid), 0);
  endtask

  task automatic set_vec(input int i, input int n, input int a,
                         input int b, input int c, input bit g,
                         input int ed, input int ec, input int ee);
    tbl[i].n      = n;
    tbl[i].w[0]   = 9'(a);
    tbl[i].w[1]   = 9'(b);
    tbl[i].w[2]   = 9'(c);
    tbl[i].w[3]   = 9'd0;
    tbl[i].gap    = g;
    tbl[i].e_data = ed;
    tbl[i].e_cnt  = ec;
    tbl[i].e_err  = ee;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    set_vec(0, 2, 400, 100,   0, 0,  39, 2, 0);
    set_vec(1, 1, 460,   0,   0, 0, 460, 1, 0);
    set_vec(2, 2, 460, 460,   0, 1, 459, 2, 0);
    set_vec(3, 2, 511,  10,   0, 0,  60, 2, 1);
    set_vec(4, 1,   5,   0,   0, 0,   5, 1, 0);
    set_vec(5, 3,   0,   0,   0, 1,   0, 3, 0);
    set_vec(6, 2, 460,   1,   0, 0,   0, 2, 0);
    set_vec(7, 2, 461,   0,   0, 1,   0, 2, 1);
    set_vec(8, 3, 200, 200, 200, 0, 139, 3, 0);

    step();
    step();
    rst = 1'b0;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_count", int'(out_count), 0);
    chk("rst_out_err", int'(out_err), 0);

    for (int i = 0; i < 9; i++) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        if (k == tbl[i].n - 1)
          push(tbl[i].e_data, tbl[i].e_cnt, tbl[i].e_err);
        send_word(int'(tbl[i].w[k]), k == tbl[i].n - 1);
        if (k == tbl[i].n - 1)
          chk($sformatf("vec%0d_latency", i), int'(out_valid), 1);
        else if (tbl[i].gap) begin
          in_data = 9'd77;
          step();
          step();
        end
      end
      collect($sformatf("vec%0d", i));
    end

    // back-pressure: result held, input ignored while presented
    send_word(1, 1'b0);
    push(3, 2, 0);
    send_word(2, 1'b1);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = 9'd100;
      in_last  = 1'b1;
      chk("stall_in_ready", int'(in_ready), 0);
      chk("stall_out_valid", int'(out_valid), 1);
      chk("stall_out_data", int'(out_data), 3);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    collect("stall");
    push(4, 1, 0);
    send_word(4, 1'b1);
    collect("post_stall");

    // reset mid-frame discards partial sum
    send_word(300, 1'b0);
    send_word(300, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_out_count", int'(out_count), 0);
    chk("midrst_out_data", int'(out_data), 0);
    push(7, 1, 0);
    send_word(7, 1'b1);
    collect("midrst");

    // reset in HOLD drops the unconsumed result
    send_word(9, 1'b1);
    chk("holdrst_pre_valid", int'(out_valid), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("holdrst_valid", int'(out_valid), 0);
    chk("holdrst_in_ready", int'(in_ready), 1);
    chk("holdrst_out_data", int'(out_data), 0);

    // count saturation
    push(300, 255, 0);
    for (int k = 0; k < 300; k++) send_word(1, k == 299);
    collect("sat");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
